// File: rtl/uc_arbiter.sv
// uc_arbiter: sits between the process engines and the shared unit clause
// queue. Push side round-robins engine unit-literal requests into the queue,
// one per cycle. Pop side dequeues a literal and broadcasts it to every
// engine until all have acknowledged.
// Optional feature: define UCA_CONFLICT_DET_EN to flag a pushed literal that
// is the negation of the literal currently being broadcast. Once flagged, the
// arbiter stops granting and popping until reset.
module uc_arbiter #(
  parameter int NUM_ENG    = 4,
  parameter int DATA_LEN   = 512,
  parameter int QUEUE_SIZE = 4,
  localparam int LIT_W     = $clog2(DATA_LEN),
  localparam int PTR_W     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_ENG-1:0]              eng_req_valid,
  input  logic [NUM_ENG-1:0][LIT_W-1:0]   eng_req_lit,
  output logic [NUM_ENG-1:0]              eng_req_ready,
  output logic                            q_push,
  output logic signed [LIT_W-1:0]         q_data,
  output logic                            q_pop,
  input  logic                            q_empty,
  input  logic                            q_full,
  input  logic signed [LIT_W-1:0]         q_qout,
  output logic                            bc_valid,
  output logic signed [LIT_W-1:0]         bc_lit,
  input  logic [NUM_ENG-1:0]              eng_ack,
  output logic                            idle,
  output logic                            conflict
);

  // The queue depth is owned by the attached ucq; it only has to be sane here.
  if (NUM_ENG < 2 || QUEUE_SIZE < 1) begin : g_param_check
    $error("uc_arbiter: NUM_ENG must be >= 2 and QUEUE_SIZE >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_BCAST = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_ENG-1:0]      ack_mask_q, ack_mask_d;
  logic                    bc_valid_q, bc_valid_d;
  logic signed [LIT_W-1:0] bc_lit_q, bc_lit_d;

  logic                    halt;        // conflict seen: freeze grants and pops
  logic [PTR_W-1:0]        cand_idx [NUM_ENG];
  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic                    grant;
  logic                    pop_req;
  logic [NUM_ENG-1:0]      ack_all;

  // Candidate k in priority order is rr_ptr+1+k, wrapping at NUM_ENG.
  for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_cand
    assign cand_idx[gi] = PTR_W'((32'(rr_ptr_q) + 32'(gi) + 32'd1) % 32'(NUM_ENG));
  end

  // Pick the first requesting engine after the last one granted.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (!grant_found && eng_req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // A grant needs room in the queue; nothing is granted while in reset.
  assign grant         = grant_found && !q_full && !halt && rst_n;
  assign eng_req_ready = grant ? (NUM_ENG'(1) << grant_idx) : '0;
  assign q_push        = grant;
  assign q_data        = eng_req_lit[grant_idx];
  assign rr_ptr_d      = grant ? grant_idx : rr_ptr_q;

  // Pop/broadcast sequencing: IDLE -> POP (queue output settles) -> BCAST.
  always_comb begin
    state_d    = state_q;
    ack_mask_d = ack_mask_q;
    bc_valid_d = bc_valid_q;
    bc_lit_d   = bc_lit_q;
    pop_req    = 1'b0;
    ack_all    = ack_mask_q | eng_ack;
    unique case (state_q)
      S_IDLE: begin
        if (!q_empty && !halt) begin
          pop_req = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: begin
        bc_lit_d   = q_qout;
        bc_valid_d = 1'b1;
        ack_mask_d = '0;
        state_d    = S_BCAST;
      end
      S_BCAST: begin
        ack_mask_d = ack_all;
        if (&ack_all) begin
          bc_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign q_pop    = pop_req & rst_n;
  assign bc_valid = bc_valid_q;
  assign bc_lit   = bc_lit_q;
  assign idle     = (state_q == S_IDLE) && q_empty && !(|eng_req_valid);

  // State, round-robin pointer and broadcast registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= PTR_W'(NUM_ENG - 1);
      ack_mask_q <= '0;
      bc_valid_q <= 1'b0;
      bc_lit_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_mask_q <= ack_mask_d;
      bc_valid_q <= bc_valid_d;
      bc_lit_q   <= bc_lit_d;
    end
  end

`ifdef UCA_CONFLICT_DET_EN
  logic conflict_q, conflict_d;

  // Sticky flag: an accepted push that contradicts the live broadcast literal.
  always_comb begin
    conflict_d = conflict_q;
    if (grant && (state_q == S_BCAST) && bc_valid_q &&
        (eng_req_lit[grant_idx] == LIT_W'(-bc_lit_q))) begin
      conflict_d = 1'b1;
    end
  end

  // Conflict register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign halt = conflict_q;
`else
  assign halt = 1'b0;
`endif

  assign conflict = halt;

endmodule

// File: tb/tb_uc_arbiter.sv
// Testbench for uc_arbiter: reset checks, a table of push-arbitration vectors,
// hand-written broadcast / reset / full-queue sequences, and a randomized run
// checked against a transaction-level reference model with a ucq model
// attached to the queue ports.
module tb_uc_arbiter;

  localparam int N  = 4;
  localparam int LW = 9;
  localparam int QS = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         eng_req_valid;
  logic [N-1:0][LW-1:0] eng_req_lit;
  logic [N-1:0]         eng_req_ready;
  logic                 q_push, q_pop, q_empty, q_full;
  logic signed [LW-1:0] q_data, q_qout;
  logic                 bc_valid;
  logic signed [LW-1:0] bc_lit;
  logic [N-1:0]         eng_ack;
  logic                 idle, conflict;

  // queue environment: either driven directly or served by the ucq model
  logic                 use_q_model;
  logic                 drv_empty, drv_full;
  logic signed [LW-1:0] drv_qout;
  logic signed [LW-1:0] mq_out;
  int                   mq[$];
  int                   mq_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] valid;
    logic         full;
    logic [N-1:0] ready;
    int           data;
    logic         idl;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  uc_arbiter #(
    .NUM_ENG   (N),
    .DATA_LEN  (512),
    .QUEUE_SIZE(QS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eng_req_valid(eng_req_valid),
    .eng_req_lit  (eng_req_lit),
    .eng_req_ready(eng_req_ready),
    .q_push       (q_push),
    .q_data       (q_data),
    .q_pop        (q_pop),
    .q_empty      (q_empty),
    .q_full       (q_full),
    .q_qout       (q_qout),
    .bc_valid     (bc_valid),
    .bc_lit       (bc_lit),
    .eng_ack      (eng_ack),
    .idle         (idle),
    .conflict     (conflict)
  );

  // ucq model: FIFO with registered output, cleared by the shared reset
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mq_cnt <= 0;
      mq_out <= '0;
    end else if (use_q_model) begin
      if (q_pop && mq.size() > 0) mq_out <= LW'(mq.pop_front());
      if (q_push) mq.push_back(int'(q_data));
      mq_cnt <= mq.size();
    end
  end

  assign q_empty = use_q_model ? (mq_cnt == 0)  : drv_empty;
  assign q_full  = use_q_model ? (mq_cnt >= QS) : drv_full;
  assign q_qout  = use_q_model ? mq_out         : drv_qout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // reference model state (transaction level)
  int           m_last;
  int           m_wait;
  bit           m_bc_on;
  int           m_bc_lit;
  int           m_pending;
  bit [N-1:0]   m_acked;
  int           expq[$];
  bit [N-1:0]   pend;
  int           plit[N];

  initial begin
    int got;
    int exp_g;
    int idx;
    bit exp_pop;
    int bc_count;

    vecs[0]  = '{4'b1111, 1'b0, 4'b0001,  5, 1'b0};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0010,  3, 1'b0};
    vecs[2]  = '{4'b0101, 1'b0, 4'b0100, -7, 1'b0};
    vecs[3]  = '{4'b0101, 1'b0, 4'b0001,  5, 1'b0};
    vecs[4]  = '{4'b0101, 1'b0, 4'b0100, -7, 1'b0};
    vecs[5]  = '{4'b1000, 1'b1, 4'b0000,  0, 1'b0};
    vecs[6]  = '{4'b1000, 1'b0, 4'b1000,  0, 1'b0};
    vecs[7]  = '{4'b0000, 1'b0, 4'b0000,  0, 1'b1};
    vecs[8]  = '{4'b1010, 1'b0, 4'b0010,  3, 1'b0};
    vecs[9]  = '{4'b1011, 1'b0, 4'b1000,  0, 1'b0};
    vecs[10] = '{4'b0011, 1'b0, 4'b0001,  5, 1'b0};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    use_q_model = 1'b0;
    drv_empty = 1'b0;
    drv_full = 1'b0;
    drv_qout = '0;
    eng_ack = '0;
    eng_req_valid = 4'b1111;
    eng_req_lit[0] = LW'(5);
    eng_req_lit[1] = LW'(3);
    eng_req_lit[2] = LW'(-7);
    eng_req_lit[3] = LW'(0);
    tick();
    tick();
    smp();
    chk("rst_ready", eng_req_ready, 0);
    chk("rst_push", q_push, 0);
    chk("rst_pop", q_pop, 0);
    chk("rst_bc_valid", bc_valid, 0);
    chk("rst_bc_lit", int'(bc_lit), 0);
    chk("rst_conflict", conflict, 0);
    tick();
    rst_n = 1'b1;
    drv_empty = 1'b1;

    // ---------------- push arbitration table ----------------
    for (int i = 0; i < 11; i++) begin
      eng_req_valid = vecs[i].valid;
      drv_full = vecs[i].full;
      smp();
      chk($sformatf("vec%0d_ready", i), eng_req_ready, vecs[i].ready);
      chk($sformatf("vec%0d_push", i), q_push, int'(|vecs[i].ready));
      if (vecs[i].ready != 0) chk($sformatf("vec%0d_data", i), int'(q_data), vecs[i].data);
      chk($sformatf("vec%0d_pop", i), q_pop, 0);
      chk($sformatf("vec%0d_idle", i), idle, vecs[i].idl);
      $display("vec %0d: valid=%b full=%b ready=%b data=%0d", i, eng_req_valid, drv_full, eng_req_ready, q_data);
      tick();
    end
    eng_req_valid = '0;
    drv_full = 1'b0;

    // ---------------- broadcast of 9, acks 2,0,2,3,1 ----------------
    drv_empty = 1'b0;
    smp(); chk("bc_pop", q_pop, 1); chk("bc_pre_valid", bc_valid, 0); tick();
    drv_empty = 1'b1; drv_qout = LW'(9); eng_ack = 4'b1111;
    smp(); chk("bc_popstate_pop", q_pop, 0); chk("bc_popstate_valid", bc_valid, 0); tick();
    drv_qout = LW'(-3); eng_ack = 4'b0100;
    smp(); chk("bc_rise", bc_valid, 1); chk("bc_lit9", int'(bc_lit), 9); tick();
    eng_ack = 4'b0001;
    smp(); chk("bc_hold_a", bc_valid, 1); tick();
    eng_ack = 4'b0100;
    smp(); chk("bc_hold_b", bc_valid, 1); tick();
    eng_ack = 4'b1000;
    smp(); chk("bc_hold_c", bc_valid, 1); chk("bc_lit_hold", int'(bc_lit), 9); tick();
    eng_ack = 4'b0010;
    smp(); chk("bc_hold_last", bc_valid, 1); tick();
    eng_ack = 4'b0000; drv_empty = 1'b0;
    smp(); chk("bc_drop", bc_valid, 0); chk("bc_next_pop", q_pop, 1); tick();
    $display("broadcast 9 done");

    // ---------------- reset in the middle of a broadcast ----------------
    drv_empty = 1'b1; drv_qout = LW'(21);
    smp(); tick();
    eng_ack = 4'b0011;
    smp(); chk("mid_valid", bc_valid, 1); chk("mid_lit", int'(bc_lit), 21); tick();
    eng_ack = 4'b0000; rst_n = 1'b0;
    smp(); tick();
    rst_n = 1'b1;
    smp(); chk("mid_rst_drop", bc_valid, 0); chk("mid_rst_pop", q_pop, 0); tick();
    drv_empty = 1'b0;
    smp(); chk("mid_pop", q_pop, 1); tick();
    drv_empty = 1'b1; drv_qout = LW'(33);
    smp(); tick();
    eng_ack = 4'b1100;
    smp(); chk("mid2_valid", bc_valid, 1); chk("mid2_lit", int'(bc_lit), 33); tick();
    eng_ack = 4'b0000;
    smp(); chk("mid2_mask_cleared", bc_valid, 1); tick();
    eng_ack = 4'b0011;
    smp(); chk("mid2_last", bc_valid, 1); tick();
    eng_ack = 4'b0000;
    smp(); chk("mid2_drop", bc_valid, 0); tick();
    $display("broadcast 33 done after reset");

    // ---------------- all engines ack in the first broadcast cycle ----------------
    drv_empty = 1'b0;
    smp(); chk("fast_pop", q_pop, 1); tick();
    drv_empty = 1'b1; drv_qout = LW'(-44);
    smp(); tick();
    eng_ack = 4'b1111;
    smp(); chk("fast_valid", bc_valid, 1); chk("fast_lit", int'(bc_lit), -44); tick();
    eng_ack = 4'b0000;
    smp(); chk("fast_drop", bc_valid, 0); chk("fast_idle", idle, 1); tick();
    $display("broadcast -44 done");

    // ---------------- full-queue stall with ucq model ----------------
    rst_n = 1'b0; use_q_model = 1'b1; eng_ack = '0; eng_req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int v = 11; v <= 15; v++) begin
      eng_req_valid = 4'b0001;
      eng_req_lit[0] = LW'(v);
      smp();
      chk($sformatf("fill%0d_ready", v), eng_req_ready, 1);
      $display("push %0d ready=%b", v, eng_req_ready);
      tick();
    end
    eng_req_lit[0] = LW'(16);
    for (int s = 0; s < 3; s++) begin
      smp();
      chk("stall_ready", eng_req_ready, 0);
      chk("stall_full", q_full, 1);
      tick();
    end
    smp(); chk("stall_bc_valid", bc_valid, 1); chk("stall_bc_lit", int'(bc_lit), 11);
    tick();
    eng_ack = 4'b1111;
    smp(); tick();
    eng_ack = 4'b0000;
    got = 0;
    for (int w = 0; w < 8 && got == 0; w++) begin
      smp();
      if (eng_req_ready[0]) got = 1;
      else tick();
    end
    chk("stall_release", got, 1);
    chk("stall_release_data", int'(q_data), 16);
    tick();
    eng_req_valid = '0;
    for (int e = 12; e <= 16; e++) begin
      got = 0;
      for (int w = 0; w < 12 && got == 0; w++) begin
        smp();
        if (bc_valid) got = 1;
        else tick();
      end
      chk($sformatf("drain%0d_seen", e), got, 1);
      chk($sformatf("drain%0d_lit", e), int'(bc_lit), e);
      $display("broadcast %0d", bc_lit);
      tick();
      eng_ack = 4'b1111;
      smp(); tick();
      eng_ack = 4'b0000;
    end
    smp(); chk("drain_empty", q_empty, 1); chk("drain_idle", idle, 1); tick();

    // ---------------- randomized run against reference model ----------------
    rst_n = 1'b0; eng_ack = '0; eng_req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    m_last = N - 1; m_wait = 0; m_bc_on = 1'b0; m_bc_lit = 0; m_pending = 0;
    m_acked = '0; expq.delete(); pend = '0;
    bc_count = 0;
    for (int i = 0; i < N; i++) plit[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          plit[i] = int'($urandom_range(1, 200));
        end
        eng_req_lit[i] = LW'(plit[i]);
        eng_ack[i] = ($urandom_range(0, 2) == 0);
      end
      eng_req_valid = pend;
      smp();
      exp_g = -1;
      if (!q_full) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (pend[idx] && exp_g < 0) exp_g = idx;
        end
      end
      exp_pop = !m_bc_on && (m_wait == 0) && !q_empty;
      chk("rnd_ready", eng_req_ready, (exp_g >= 0) ? (1 << exp_g) : 0);
      chk("rnd_push", q_push, int'(exp_g >= 0));
      if (exp_g >= 0) chk("rnd_data", int'(q_data), plit[exp_g]);
      chk("rnd_pop", q_pop, int'(exp_pop));
      chk("rnd_bc_valid", bc_valid, int'(m_bc_on));
      if (m_bc_on) chk("rnd_bc_lit", int'(bc_lit), m_bc_lit);
      chk("rnd_idle", idle, int'(!m_bc_on && m_wait == 0 && q_empty && pend == 0));
      chk("rnd_qcount", mq_cnt, expq.size());
      chk("rnd_conflict", conflict, 0);
      if (m_bc_on) begin
        m_acked |= eng_ack;
        if (&m_acked) begin
          m_bc_on = 1'b0;
          bc_count++;
          $display("rnd broadcast %0d lit=%0d cycle=%0d", bc_count, m_bc_lit, c);
        end
      end else if (m_wait != 0) begin
        m_wait = 0;
        m_bc_on = 1'b1;
        m_bc_lit = m_pending;
        m_acked = '0;
      end else if (exp_pop) begin
        m_wait = 1;
        if (expq.size() > 0) m_pending = expq.pop_front();
      end
      if (exp_g >= 0) begin
        expq.push_back(plit[exp_g]);
        m_last = exp_g;
        pend[exp_g] = 1'b0;
      end
      tick();
    end
    chk("rnd_progress", int'(bc_count > 10), 1);

`ifdef UCA_CONFLICT_DET_EN
    // ---------------- conflict detection ----------------
    rst_n = 1'b0; use_q_model = 1'b0; eng_ack = '0; eng_req_valid = '0;
    drv_empty = 1'b1; drv_full = 1'b0;
    tick();
    rst_n = 1'b1; drv_empty = 1'b0;
    smp(); chk("cf_pop", q_pop, 1); tick();
    drv_empty = 1'b1; drv_qout = LW'(5);
    smp(); tick();
    eng_req_valid = 4'b0010; eng_req_lit[1] = LW'(-5);
    smp(); chk("cf_bc_lit", int'(bc_lit), 5); chk("cf_grant", eng_req_ready, 4'b0010);
    chk("cf_before", conflict, 0); tick();
    eng_req_valid = 4'b1111; drv_empty = 1'b0;
    smp(); chk("cf_set", conflict, 1); chk("cf_no_grant", eng_req_ready, 0); tick();
    eng_ack = 4'b1111;
    smp(); tick();
    eng_ack = 4'b0000;
    smp(); chk("cf_bc_done", bc_valid, 0); chk("cf_no_pop", q_pop, 0); tick();
    smp(); chk("cf_sticky", conflict, 1); chk("cf_still_no_grant", eng_req_ready, 0); tick();
    rst_n = 1'b0;
    smp(); tick();
    rst_n = 1'b1;
    smp(); chk("cf_cleared", conflict, 0); tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uc_arbiter.md
Name: uc_arbiter

Overview:
Unit Clause Arbiter (uca) sits between NUM_ENG process engines and the shared Unit Clause Queue (ucq).
- Push side: round-robin arbitration of engine unit-literal requests into the ucq, at most one push per cycle.
- Pop side: sequences pops and broadcasts each dequeued literal to all engines, holding it until every engine has acknowledged.

Parameters:
NUM_ENG, 4, number of process engines (requesters and broadcast receivers)
DATA_LEN, 512, literal range; literal width LIT_W = $clog2(DATA_LEN), signed
QUEUE_SIZE, 4, depth of the attached ucq (informational; full/empty come from the queue)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
eng_req_valid  in  NUM_ENG  per-engine unit-literal request
eng_req_lit  in  NUM_ENG x LIT_W signed  per-engine literal
eng_req_ready  out  NUM_ENG  one-hot grant; transfer when valid&ready
q_push  out  1  push strobe to ucq
q_data  out  LIT_W signed  literal to ucq
q_pop  out  1  pop strobe to ucq
q_empty  in  1  ucq empty
q_full  in  1  ucq full
q_qout  in  LIT_W signed  ucq registered output, valid the cycle after q_pop
bc_valid  out  1  broadcast literal valid
bc_lit  out  LIT_W signed  broadcast literal
eng_ack  in  NUM_ENG  per-engine broadcast acknowledge
idle  out  1  FSM in IDLE, q_empty=1, no eng_req_valid asserted
conflict  out  1  see Optional Feature

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, rr_ptr=NUM_ENG-1 (engine 0 highest priority first), ack_mask=0, bc_valid=0, bc_lit=0, conflict=0.
- Outputs during reset: q_push, q_pop and eng_req_ready are 0 while rst_n=0.
- Push arbitration is combinational in-cycle:
  - Priority order is rr_ptr+1, rr_ptr+2, ... modulo NUM_ENG.
  - Grant goes to the first engine with eng_req_valid=1, only if q_full=0.
  - On grant: eng_req_ready=onehot(g), q_push=1, q_data=eng_req_lit[g]; rr_ptr<=g at clk edge.
  - With no grant, rr_ptr holds.
- Push when full: q_full=1 → no grant, all ready=0, requests stall; the engine must hold valid and lit stable.
- Pop FSM:
  - IDLE: if q_empty=0 → q_pop=1, go POP.
  - POP (1 cycle): capture bc_lit<=q_qout, bc_valid<=1, ack_mask<=0, go BCAST.
  - BCAST: ack_mask<=ack_mask|eng_ack. When (ack_mask|eng_ack) is all ones → bc_valid<=0, go IDLE.
  - Acks arriving while bc_valid=0, and repeated acks, are ignored.
- Latency:
  - Pop to bc_valid visible is 2 cycles.
  - Last ack to bc_valid=0 is 1 cycle.
  - Minimum spacing between broadcasts is 3 cycles.
- Push and pop in the same cycle are allowed. q_pop is issued only when q_empty=0, so push+pop on an empty queue never occurs.
- The push grant does not depend on q_pop; a simultaneous push+pop on a full queue does not occur because push is blocked when q_full=1.
- All engines acking in the same cycle as bc_valid's first cycle: exit BCAST after 1 cycle.
- Reset asserted mid-BCAST: bc_valid drops the next cycle and ack_mask clears. Queue contents belong to the ucq's own reset.
- Literal 0 is passed through unmodified; the arbiter does no range checking.

Optional Feature:
Macro UCA_CONFLICT_DET_EN.
- Defined:
  - In BCAST with bc_valid=1, an accepted push (valid&ready) whose literal equals -bc_lit sets conflict<=1 on the next edge. The offending literal is still pushed.
  - conflict is sticky until reset.
  - While conflict=1: no grants (eng_req_ready=0), no q_pop; the current broadcast still completes to IDLE.
- Undefined: conflict tied 0; no comparator logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with eng_req_valid=4'b1111 → eng_req_ready=0, q_push=0, q_pop=0, bc_valid=0, conflict=0. After release, first grant goes to engine 0.
- Round robin: engines 0 and 2 valid constantly, literals 5 and -7, q_full=0 → q_data sequence 5, -7, 5, -7 on consecutive cycles; ready alternates 0001 / 0100.
- Full stall: push 4 literals into a QUEUE_SIZE=4 ucq with pop side blocked (one engine never acks) → 5th request sees ready=0 until a pop frees a slot. Then it is granted; no literal is lost or duplicated.
- Broadcast: ucq holds 9, engines ack in order 2, 0, 3, 1 on separate cycles (engine 2 acks twice) → bc_valid rises 2 cycles after q_pop with bc_lit=9, stays high until the cycle after engine 1's ack, then drops. Next q_pop occurs the following cycle if the queue is non-empty.
- Reset mid-broadcast: rst_n=0 for 1 cycle while in BCAST with ack_mask=4'b0011 → bc_valid=0 the next cycle. After release, a full 4-engine ack is required for the next broadcast.
- Conflict (UCA_CONFLICT_DET_EN defined): bc_lit=5 in BCAST, engine 1 requests -5 → pushed, conflict=1 the next cycle. All subsequent eng_req_ready=0 and q_pop=0 until reset.
